mux3: RTL and testbench

MUX3 -- requirements
Module: mux3

---
 rtl/mux3_pkg.sv | 11 +
 rtl/flopenr.sv | 30 +++
 rtl/mux3.sv | 46 ++++
 tb/tb_mux3.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mux3_pkg.sv
// Shared select encodings for the three-input data mux.
package mux3_pkg;

    typedef enum logic [1:0] {
        SEL_D0   = 2'b00,
        SEL_D1   = 2'b01,
        SEL_D2   = 2'b10,
        SEL_NONE = 2'b11
    } sel_e;

endpackage : mux3_pkg

// File: rtl/flopenr.sv
// Parameterised register with load enable and synchronous active-low reset.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = en_i ? d_i : q_q;
    end

    // Reset wins over the enable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : flopenr

// File: rtl/mux3.sv
// Three-input data mux with an invalid-select flag and a registered copy of both outputs.
module mux3
    import mux3_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [1:0]       s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic             invalid,
    output logic [WIDTH-1:0] y_q,
    output logic             invalid_q
);

    // An unknown select falls through to default so the output goes X in simulation.
    always_comb begin
        y       = '0;
        invalid = 1'b0;
        case (s)
            SEL_D0:   y = d0;
            SEL_D1:   y = d1;
            SEL_D2:   y = d2;
            SEL_NONE: invalid = 1'b1;
            default: begin
                y       = 'x;
                invalid = 1'bx;
            end
        endcase
    end

    flopenr #(
        .WIDTH(WIDTH + 1)
    ) u_out_reg (
        .clk_i  (clock),
        .rst_ni (reset),
        .en_i   (en),
        .d_i    ({invalid, y}),
        .q_o    ({invalid_q, y_q})
    );

endmodule : mux3

// File: tb/tb_mux3.sv
// Directed self-checking bench for mux3 at WIDTH = 4.
module tb_mux3;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [1:0]   s;
    logic         en;
    logic [W-1:0] y;
    logic         invalid;
    logic [W-1:0] y_q;
    logic         invalid_q;

    int n_checks = 0;
    int n_fail   = 0;

    mux3 #(
        .WIDTH(W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .s         (s),
        .en        (en),
        .y         (y),
        .invalid   (invalid),
        .y_q       (y_q),
        .invalid_q (invalid_q)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        s     = 2'b00;
        d0    = 4'h1;
        d1    = 4'h8;
        d2    = 4'hF;

        // Reset with en low still clears the registers.
        tick();
        tick();
        check("reset_y_q", 32'(y_q), 32'h0);
        check("reset_invalid_q", 32'(invalid_q), 32'h0);
        check("reset_no_effect_y", 32'(y), 32'h1);

        reset = 1'b1;

        // Walk the valid selects at 100 ns intervals.
        s = 2'b00; #1;
        check("sel00_y", 32'(y), 32'h1);
        check("sel00_invalid", 32'(invalid), 32'h0);
        #99;
        s = 2'b01; #1;
        check("sel01_y", 32'(y), 32'h8);
        check("sel01_invalid", 32'(invalid), 32'h0);
        #99;
        s = 2'b10; #1;
        check("sel10_y", 32'(y), 32'hF);
        check("sel10_invalid", 32'(invalid), 32'h0);
        check("en_low_hold_y_q", 32'(y_q), 32'h0);

        // Invalid select.
        s = 2'b11; #1;
        check("sel11_y", 32'(y), 32'h0);
        check("sel11_invalid", 32'(invalid), 32'h1);
        en = 1'b1;
        tick();
        check("sel11_y_q", 32'(y_q), 32'h0);
        check("sel11_invalid_q", 32'(invalid_q), 32'h1);

        // One-edge load latency, then hold with en low.
        s = 2'b01; #1;
        check("load_pre_y_q", 32'(y_q), 32'h0);
        tick();
        check("load_y_q", 32'(y_q), 32'h8);
        check("load_invalid_q", 32'(invalid_q), 32'h0);
        en = 1'b0;
        s  = 2'b10; #1;
        check("hold_y", 32'(y), 32'hF);
        tick();
        check("hold_y_q", 32'(y_q), 32'h8);
        tick();
        check("hold2_y_q", 32'(y_q), 32'h8);

        // Reset beats en.
        reset = 1'b0;
        en    = 1'b1;
        s     = 2'b10;
        tick();
        check("rst_pri_y_q", 32'(y_q), 32'h0);
        check("rst_pri_invalid_q", 32'(invalid_q), 32'h0);
        check("rst_pri_y", 32'(y), 32'hF);
        reset = 1'b1;

        // Data change shows up combinationally, register waits for an edge.
        en = 1'b0;
        s  = 2'b01;
        d1 = 4'h3; #1;
        check("d1_change_y", 32'(y), 32'h3);
        check("d1_change_y_q_wait", 32'(y_q), 32'h0);
        tick();
        check("d1_change_en_low_y_q", 32'(y_q), 32'h0);
        en = 1'b1;
        tick();
        check("d1_change_y_q", 32'(y_q), 32'h3);

        // Mid-operation reset with an invalid select, then resume.
        s = 2'b11;
        tick();
        check("mid_invalid_q", 32'(invalid_q), 32'h1);
        reset = 1'b0;
        tick();
        check("mid_rst_invalid_q", 32'(invalid_q), 32'h0);
        check("mid_rst_invalid", 32'(invalid), 32'h1);
        reset = 1'b1;
        s = 2'b00;
        tick();
        check("resume_y_q", 32'(y_q), 32'h1);
        check("resume_invalid_q", 32'(invalid_q), 32'h0);

        // A few more data patterns through each select.
        d0 = 4'hA; d1 = 4'h5; d2 = 4'h6;
        s = 2'b00; #1; check("pat_d0", 32'(y), 32'hA);
        s = 2'b01; #1; check("pat_d1", 32'(y), 32'h5);
        s = 2'b10; #1; check("pat_d2", 32'(y), 32'h6);
        tick();
        check("pat_d2_y_q", 32'(y_q), 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux3
